// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit
//   Owns the SDRAM command/address/data pins and hands them to one of the
//   sub-controllers (init, auto-refresh, write, read) at a time.
//   - INIT  : pins follow the init_* inputs until init_end is seen.
//   - ARBIT : NOP on the bus; one registered decision per cycle,
//             priority refresh > write > read.
//   - AREF/WRITE/READ : pins follow the granted requester. The matching grant
//             stays high until that requester's *_end pulse, then the FSM goes
//             back through ARBIT. There is no preemption.
//
// Optional feature (macro SDRAM_ARBIT_RR_EN):
//   If write and read are pending together with no refresh pending, they
//   alternate using a last_grant register (reset value = READ, so the first
//   contested grant goes to WRITE). If the macro is undefined, write always
//   wins over read.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   init_cmd/ba/addr, init_end       init sequencer bus and done level
//   aref_req/cmd/ba/addr/end         auto-refresh requester
//   wr_req/cmd/ba/addr/end           write requester
//   wr_sdram_en, wr_data             write data and DQ drive request
//   rd_req/cmd/ba/addr/end           read requester
//   aref_en, wr_en, rd_en            one-hot level grants
//   rd_data                          sdram_dq passthrough
//   sdram_cke/cs_n/ras_n/cas_n/we_n  SDRAM control pins
//   sdram_ba, sdram_addr, sdram_dq   SDRAM bank, address and data pins
// ---------------------------------------------------------------------------
module sdram_arbit #(
  parameter int          ADDR_W  = 13,
  parameter int          BA_W    = 2,
  parameter int          DATA_W  = 16,
  parameter logic [3:0]  CMD_NOP = 4'b0111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              aref_end,
  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_end,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_end,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DATA_W-1:0] sdram_dq
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t state, state_nx;

  // Write-vs-read tie-break when both are pending in ARBIT.
  logic pick_wr;

`ifdef SDRAM_ARBIT_RR_EN
  // 1 = the most recent WRITE/READ grant was READ; refresh leaves it alone.
  logic last_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_rd <= 1'b1;
    else if (state == S_ARBIT && state_nx == S_WRITE)
      last_rd <= 1'b0;
    else if (state == S_ARBIT && state_nx == S_READ)
      last_rd <= 1'b1;
  end

  assign pick_wr = last_rd;
`else
  assign pick_wr = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT:  if (init_end) state_nx = S_ARBIT;
      S_ARBIT: begin
        if (aref_req)               state_nx = S_AREF;
        else if (wr_req && rd_req)  state_nx = pick_wr ? S_WRITE : S_READ;
        else if (wr_req)            state_nx = S_WRITE;
        else if (rd_req)            state_nx = S_READ;
      end
      S_AREF:  if (aref_end) state_nx = S_ARBIT;
      S_WRITE: if (wr_end)   state_nx = S_ARBIT;
      S_READ:  if (rd_end)   state_nx = S_ARBIT;
      default: state_nx = S_INIT;
    endcase
  end

  // Output logic: grants decode straight from state so an async reset drops
  // them (and the DQ driver) without waiting for a clock edge.
  logic [3:0] cmd;

  always_comb begin
    aref_en    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    cmd        = CMD_NOP;
    sdram_ba   = '0;
    sdram_addr = '0;
    unique case (state)
      S_INIT: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        aref_en    = 1'b1;
        cmd        = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      S_WRITE: begin
        wr_en      = 1'b1;
        cmd        = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      S_READ: begin
        rd_en      = 1'b1;
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke = 1'b1;

  assign sdram_dq = (state == S_WRITE && wr_sdram_en) ? wr_data : 'z;
  assign rd_data  = sdram_dq;

endmodule
